// File: rtl/sint_addsub_pkg.sv
// Shared definitions for the signed add/sub pipeline: op encoding, stage payload layout
// (a macro because package typedefs cannot take the caller's WIDTH) and the saturation helper.
package sint_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned MAX_WIDTH = 64;

`ifndef SINT_ADDSUB_PAYLOAD_T
`define SINT_ADDSUB_PAYLOAD_T(W) struct packed { logic [(W)-1:0] result; logic overflow; }
`endif

  // Largest positive (neg=0) or most negative (neg=1) value of a width-bit two's complement
  // number, returned in the low bits of a MAX_WIDTH vector.
  function automatic logic [MAX_WIDTH-1:0] sat_value(input int unsigned width, input logic neg);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i + 1 < width) begin
        v[i] = ~neg;
      end else if (i + 1 == width) begin
        v[i] = neg;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/sint_addsub_stage.sv
// One elastic register stage: 1-cycle latency; loads when empty or downstream ready,
// otherwise valid and data hold so a stalled result never changes.
module sint_addsub_stage #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          src_valid,
  input  logic [DW-1:0] src_data,
  input  logic          dst_ready,
  output logic          valid,
  output logic [DW-1:0] data
);

  logic load;

  assign load = ~valid | dst_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= src_valid;
      data  <= src_data;
    end
  end

endmodule

// File: rtl/sint_addsub_pipe.sv
// Pipelined signed add/sub, STAGES cycles latency, 1 op/cycle; O_ready stalls the whole chain
// combinationally back to I_ready. Define SINT_ADDSUB_PIPE_SAT_EN to saturate instead of wrap.
module sint_addsub_pipe
  import sint_addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 7,
  parameter int unsigned STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             I_valid,
  output logic             I_ready,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             op,
  output logic             O_valid,
  input  logic             O_ready,
  output logic [WIDTH-1:0] O,
  output logic             overflow
);

  typedef `SINT_ADDSUB_PAYLOAD_T(WIDTH) payload_t;
  localparam int unsigned PW = $bits(payload_t);

  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   raw;
  logic             raw_ovf;
  logic [WIDTH-1:0] res;
  payload_t         pay_in;
  payload_t         pay_out;

  // One guard bit makes the WIDTH+1 sum exact, so overflow is a mismatch of the top two bits.
  assign a_ext   = {I0[WIDTH-1], I0};
  assign b_ext   = {I1[WIDTH-1], I1};
  assign raw     = (op == OP_ADD) ? (a_ext + b_ext) : (a_ext - b_ext);
  assign raw_ovf = raw[WIDTH] ^ raw[WIDTH-1];

`ifdef SINT_ADDSUB_PIPE_SAT_EN
  assign res = raw_ovf ? WIDTH'(sat_value(WIDTH, raw[WIDTH])) : raw[WIDTH-1:0];
`else
  assign res = raw[WIDTH-1:0];
`endif

  assign pay_in.result   = res;
  assign pay_in.overflow = raw_ovf;

  logic [STAGES-1:0] stage_vld;
  logic [STAGES:0]   stage_rdy;
  logic [PW-1:0]     stage_dat [STAGES];

  // Stage k can load unless it and every stage after it are full while O_ready is low;
  // derived from the valid flops directly so the ready path has no feedback through itself.
  assign stage_rdy[STAGES] = O_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_rdy
    assign stage_rdy[k] = O_ready | ~(&stage_vld[STAGES-1:k]);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic          src_valid;
    logic [PW-1:0] src_data;

    if (k == 0) begin : g_head
      assign src_valid = I_valid;
      assign src_data  = pay_in;
    end else begin : g_body
      assign src_valid = stage_vld[k-1];
      assign src_data  = stage_dat[k-1];
    end

    sint_addsub_stage #(
      .DW(PW)
    ) u_stage (
      .clk       (CLK),
      .rst       (RESET),
      .src_valid (src_valid),
      .src_data  (src_data),
      .dst_ready (stage_rdy[k+1]),
      .valid     (stage_vld[k]),
      .data      (stage_dat[k])
    );
  end

  assign pay_out  = stage_dat[STAGES-1];
  assign I_ready  = stage_rdy[0];
  assign O_valid  = stage_vld[STAGES-1];
  assign O        = pay_out.result;
  assign overflow = pay_out.overflow;

endmodule

// File: tb/tb_sint_addsub_pipe.sv
// Directed-vector and reference-model bench for sint_addsub_pipe (WIDTH=7, STAGES=2 main
// instance, plus STAGES=1 and STAGES=4 instances for latency).
`timescale 1ns/1ps
module tb_sint_addsub_pipe;

  localparam int W = 7;
  localparam int S = 2;
  localparam int N = 10;
`ifdef SINT_ADDSUB_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] exp_o;
    logic         exp_ovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid, i_ready, op;
  logic         o_valid, o_ready, ovf;
  logic [W-1:0] i0, i1, o;
  logic         lat_valid;
  logic         l1_ready, l1_valid, l1_ovf;
  logic         l4_ready, l4_valid, l4_ovf;
  logic [W-1:0] l1_o, l4_o;

  int checks = 0;
  int errors = 0;

  vec_t vecs [N];
  vec_t st [3];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  sint_addsub_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
    .CLK(clk), .RESET(rst), .I_valid(i_valid), .I_ready(i_ready), .I0(i0), .I1(i1), .op(op),
    .O_valid(o_valid), .O_ready(o_ready), .O(o), .overflow(ovf)
  );

  sint_addsub_pipe #(.WIDTH(W), .STAGES(1)) u_dut1 (
    .CLK(clk), .RESET(rst), .I_valid(lat_valid), .I_ready(l1_ready), .I0(i0), .I1(i1), .op(op),
    .O_valid(l1_valid), .O_ready(1'b1), .O(l1_o), .overflow(l1_ovf)
  );

  sint_addsub_pipe #(.WIDTH(W), .STAGES(4)) u_dut4 (
    .CLK(clk), .RESET(rst), .I_valid(lat_valid), .I_ready(l4_ready), .I0(i0), .I1(i1), .op(op),
    .O_valid(l4_valid), .O_ready(1'b1), .O(l4_o), .overflow(l4_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int r;
    logic v;
    logic [W-1:0] res;
    r = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
    v = (r > 63) || (r < -64);
    res = r[W-1:0];
    if (SAT && v) res = (r > 0) ? 7'h3F : 7'h40;
    return {v, res};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int k, got, idx;
    logic [7:0] e;
    logic stalled, prev_ovf;
    logic [W-1:0] prev_o;

    vecs[0] = '{7'h14, 7'h1E, 1'b1, 7'h76, 1'b0};                     // 20-30 = -10
    vecs[1] = '{7'h7B, 7'h0C, 1'b0, 7'h07, 1'b0};                     // -5+12 = 7
    vecs[2] = '{7'h3F, 7'h01, 1'b0, SAT ? 7'h3F : 7'h40, 1'b1};       // 63+1
    vecs[3] = '{7'h40, 7'h01, 1'b1, SAT ? 7'h40 : 7'h3F, 1'b1};       // -64-1
    vecs[4] = '{7'h40, 7'h40, 1'b0, SAT ? 7'h40 : 7'h00, 1'b1};       // -64+-64
    vecs[5] = '{7'h40, 7'h40, 1'b1, 7'h00, 1'b0};                     // -64-(-64)
    vecs[6] = '{7'h3F, 7'h7F, 1'b1, SAT ? 7'h3F : 7'h40, 1'b1};       // 63-(-1)
    vecs[7] = '{7'h1E, 7'h21, 1'b0, 7'h3F, 1'b0};                     // 30+33
    vecs[8] = '{7'h7F, 7'h3F, 1'b1, 7'h40, 1'b0};                     // -1-63
    vecs[9] = '{7'h00, 7'h00, 1'b0, 7'h00, 1'b0};
    st[0]   = '{7'h0A, 7'h05, 1'b0, 7'h0F, 1'b0};                     // 10+5
    st[1]   = '{7'h01, 7'h02, 1'b1, 7'h7F, 1'b0};                     // 1-2
    st[2]   = '{7'h03, 7'h03, 1'b0, 7'h06, 1'b0};                     // 3+3

    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1; lat_valid = 1'b0;
    i0 = '0; i1 = '0; op = 1'b0;
    tick();
    tick();
    chk("reset_o_valid", o_valid, 0);
    chk("reset_o", o, 0);
    chk("reset_overflow", ovf, 0);
    chk("reset_i_ready", i_ready, 1);
    rst = 1'b0;

    // Back-to-back stream with O_ready held high
    for (int ei = 0; ei < N + S - 1; ei++) begin
      if (ei < N) begin
        i0 = vecs[ei].a; i1 = vecs[ei].b; op = vecs[ei].sub; i_valid = 1'b1;
        #1 chk("stream_i_ready", i_ready, 1);
      end else begin
        i_valid = 1'b0;
      end
      tick();
      idx = ei - S + 1;
      if (idx >= 0) begin
        chk("stream_o_valid", o_valid, 1);
        chk("stream_o", o, vecs[idx].exp_o);
        chk("stream_overflow", ovf, vecs[idx].exp_ovf);
      end else begin
        chk("stream_fill_o_valid", o_valid, 0);
      end
    end
    tick();
    chk("bubble_o_valid", o_valid, 0);

    // Stall: exactly S ops accepted, output held
    o_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      i_valid = (k < 3);
      if (k < 3) begin i0 = st[k].a; i1 = st[k].b; op = st[k].sub; end
      #1 chk("stall_i_ready", i_ready, (c < S));
      if (i_valid && i_ready) k++;
      tick();
      if (c >= S - 1) begin
        chk("stall_o_valid", o_valid, 1);
        chk("stall_o", o, st[0].exp_o);
      end
    end
    chk("stall_accepted", k, S);

    // Drain in order
    i_valid = 1'b0;
    o_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      if (o_valid) begin
        if (got < S) chk("drain_o", o, st[got].exp_o);
        got++;
      end
      tick();
    end
    chk("drain_count", got, S);

    // Reset with two ops in flight
    i_valid = 1'b1; i0 = 7'h0A; i1 = 7'h0A; op = 1'b0;
    tick();
    i0 = 7'h14;
    tick();
    chk("preflush_o_valid", o_valid, 1);
    rst = 1'b1; i0 = 7'h05; i1 = 7'h05;
    tick();
    chk("flush_o_valid", o_valid, 0);
    chk("flush_o", o, 0);
    chk("flush_overflow", ovf, 0);
    chk("flush_i_ready", i_ready, 1);
    rst = 1'b0; i0 = 7'h03; i1 = 7'h04; op = 1'b0;
    tick();
    i_valid = 1'b0;
    for (int c = 1; c < S; c++) begin
      chk("postflush_wait_valid", o_valid, 0);
      tick();
    end
    chk("postflush_o_valid", o_valid, 1);
    chk("postflush_o", o, 7'h07);
    chk("postflush_overflow", ovf, 0);
    tick();

    // Latency of STAGES=1 and STAGES=4 builds (5-9 = -4)
    i0 = 7'h05; i1 = 7'h09; op = 1'b1; lat_valid = 1'b1;
    #1 chk("lat_l1_ready", l1_ready, 1);
    chk("lat_l4_ready", l4_ready, 1);
    tick();
    lat_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk("lat1_valid", l1_valid, (c == 1));
      chk("lat4_valid", l4_valid, (c == 4));
      if (c == 1) begin
        chk("lat1_o", l1_o, 7'h7C);
        chk("lat1_ovf", l1_ovf, 0);
      end
      if (c == 4) begin
        chk("lat4_o", l4_o, 7'h7C);
        chk("lat4_ovf", l4_ovf, 0);
      end
      tick();
    end

    // Random traffic with random backpressure against the reference model
    stalled = 1'b0; prev_o = '0; prev_ovf = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (stalled) begin
        chk("rand_hold_valid", o_valid, 1);
        chk("rand_hold_o", o, prev_o);
        chk("rand_hold_ovf", ovf, prev_ovf);
      end
      i_valid = ($urandom_range(0, 3) != 0);
      o_ready = ($urandom_range(0, 3) != 0);
      i0 = W'($urandom);
      i1 = W'($urandom);
      op = 1'($urandom);
      #1;
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rand_extra_output: got O=%0h with no operation outstanding", o);
        end else begin
          e = exp_q.pop_front();
          chk("rand_o", o, e[6:0]);
          chk("rand_ovf", ovf, e[7]);
        end
      end
      if (i_valid && i_ready) exp_q.push_back(model(i0, i1, op));
      stalled = o_valid && !o_ready;
      prev_o = o;
      prev_ovf = ovf;
      tick();
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    for (int c = 0; c < S + 2; c++) begin
      if (o_valid && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rand_drain_o", o, e[6:0]);
        chk("rand_drain_ovf", ovf, e[7]);
      end
      tick();
    end
    chk("rand_all_drained", exp_q.size(), 0);
    chk("rand_idle_o_valid", o_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
